// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and
// the select/operation codes it drives onto the datapath.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/control_fsm.sv
// Moore control FSM for a multicycle RISC-V datapath. Outputs decode from the
// registered state only; PCWrite alone folds in the ALU Zero flag for branches.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               Zero,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               PCWrite,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // op is only consulted in DECODE and MEMADR; every other state ignores it.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Unused state codes fall through to the all-zero defaults.
  always_comb begin
    ALUOp     = ALUOP_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_REG;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_REG;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign state   = STATE_W'(state_q);

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 4, which is the width of the state register and of the state debug output.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port op, input, 7 bits, the opcode field of the instruction register.
REQ-005 SHALL have port Zero, input, 1 bit, the ALU zero flag.
REQ-006 SHALL have port ALUOp, output, 2 bits, driven to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded, 11 = never driven.
REQ-007 SHALL have ports ALUSrcA and ALUSrcB, output, 2 bits each, the ALU operand-select controls.
REQ-008 SHALL have port ResultSrc, output, 2 bits, the result-bus select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-009 SHALL have ports AdrSrc, IRWrite, MemWrite and RegWrite, output, 1 bit each.
REQ-010 SHALL have port PCWrite, output, 1 bit, defined as PCUpdate OR (Branch AND Zero).
REQ-011 SHALL have port state, output, STATE_W bits, the current state code, provided for debug.

Function
REQ-012 SHALL be a Moore FSM with 11 states:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
- EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10
REQ-013 SHALL use these transitions:
- FETCH->DECODE.
- DECODE: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other opcode -> FETCH.
- MEMADR: 0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER, EXECUTEI and JAL -> ALUWB; ALUWB->FETCH; BEQ->FETCH.
REQ-014 SHALL drive outputs as a function of state only, with unlisted outputs 0 in that state:
- FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-015 SHALL make PCWrite the only output that depends on an input (Zero), and only in BEQ.
REQ-016 SHALL take op-dependent decisions only in DECODE and MEMADR; changes of op in any other state SHALL have no effect.
REQ-017 SHALL produce these per-instruction cycle counts: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, unsupported opcode 2.
REQ-018 SHALL treat an unreachable state code (11..15) as FETCH for the next state, with all outputs 0.
REQ-019 SHALL never assert MemWrite and RegWrite in the same cycle, and SHALL never assert IRWrite outside FETCH.

Reset
REQ-020 SHALL, while reset is high, immediately force state=FETCH, independent of clk.
REQ-021 SHALL therefore show the FETCH output values during reset.
REQ-022 SHALL, when reset asserts mid-instruction, abandon that instruction with no further write strobes; the first rising edge after reset deasserts SHALL move the FSM to DECODE.

Structure
REQ-023 SHALL place in the shared package: the state codes, the opcode constants (LW, SW, RTYPE, ITYPE, JAL, BEQ), and the ALUOp and ResultSrc encodings.
REQ-024 SHALL implement the state register, next-state logic and output decode in one module; no sub-module is required.

Verification
REQ-025 lw: reset, then op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in the 5th cycle; ResultSrc=01 in that cycle.
REQ-026 sw: op=0100011 -> states 0,1,2,5,0; MemWrite=1 for exactly 1 cycle with AdrSrc=1 in that cycle.
REQ-027 R-type: op=0110011 -> ALUOp=10 in EXECUTER, RegWrite=1 in ALUWB; 4 cycles total.
REQ-028 beq: op=1100011 with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0 in BEQ; return to FETCH in both cases.
REQ-029 Unsupported opcode: op=1110011 -> DECODE->FETCH; no MemWrite or RegWrite asserted.
REQ-030 Reset mid-operation: assert reset in MEMWRITE between clock edges -> state=0 and MemWrite=0 before the next edge; FETCH resumes after deassertion.
